// File: rtl/cpu_multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, ALU codes,
// opcodes, datapath select encodings and immediate formats.
package cpu_multicycle_control_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_JMP,
    S_LUI, S_AUIPC, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD, ALU_OP_BRANCH, ALU_OP_FUNCT
  } alu_op_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [2:0] IMM_SRC_I    = 3'd0;
  localparam logic [2:0] IMM_SRC_S    = 3'd1;
  localparam logic [2:0] IMM_SRC_B    = 3'd2;
  localparam logic [2:0] IMM_SRC_U    = 3'd3;
  localparam logic [2:0] IMM_SRC_J    = 3'd4;

endpackage

// File: rtl/cpu_multicycle_control_alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields to a concrete ALU code.
module cpu_alu_decoder
  import cpu_multicycle_control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  input  alu_op_t    alu_op,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_BRANCH: begin
        if (!funct3[2])     alu_control = ALU_SUB;
        else if (funct3[1]) alu_control = ALU_SLTU;
        else                alu_control = ALU_SLT;
      end
      ALU_OP_FUNCT: begin
        case (funct3)
          // funct7_5 is part of the immediate for addi, so SUB is R-type only
          3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Control FSM for a shared-ALU, shared-memory multicycle RV32I datapath.
module cpu_multicycle_control
  import cpu_multicycle_control_pkg::*;
#(
  parameter int unsigned RESET_PC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       halted,
  output logic       illegal
);

  localparam logic [3:0] WAIT_LAST = 4'(RESET_PC_WAIT - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  alu_op_t    alu_op;
  logic       is_rtype;
  logic       branch_bad;
  logic       branch_take;

  assign branch_bad  = (funct3[2:1] == 2'b01);
  assign branch_take = (funct3[2] ? ~zero : zero) ^ funct3[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == S_RESET && state_next == S_RESET) ? wait_cnt + 4'd1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:  state_next = (wait_cnt == WAIT_LAST) ? S_FETCH : S_RESET;
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR_ADR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          OP_FENCE:          state_next = S_FETCH;
          OP_SYSTEM:         state_next = S_HALT;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R:   state_next = S_ALUWB;
      S_EXEC_I:   state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = branch_bad ? S_TRAP : S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_JALR_ADR: state_next = S_JALR_JMP;
      S_JALR_JMP: state_next = S_ALUWB;
      S_LUI:      state_next = S_ALUWB;
      S_AUIPC:    state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_SRC_I;
    halted     = 1'b0;
    illegal    = 1'b0;
    alu_op     = ALU_OP_ADD;
    is_rtype   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        if (op == OP_BRANCH)   imm_src = IMM_SRC_B;
        else if (op == OP_JAL) imm_src = IMM_SRC_J;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (op == OP_LOAD) ? IMM_SRC_I : IMM_SRC_S;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_FUNCT;
        is_rtype  = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_BRANCH;
        pc_write  = branch_take && !branch_bad;
      end
      S_JAL, S_JALR_JMP: begin
        pc_write  = 1'b1;
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
      end
      S_JALR_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_SRC_U;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_SRC_U;
      end
      S_HALT:  halted  = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  cpu_alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_rtype    (is_rtype),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Directed bench for cpu_multicycle_control: per-cycle expected output vectors go
// through a scoreboard queue and are compared on the falling edge.
module tb_cpu_multicycle_control;

  localparam int unsigned RST_WAIT = 2;

  localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_4 = 2'd2;
  localparam logic [1:0] RS_OUT = 2'd0, RS_MEM = 2'd1, RS_ALU = 2'd2;
  localparam logic [3:0] K_ADD = 4'd0, K_SUB = 4'd1, K_AND = 4'd2, K_SLT = 4'd5,
                         K_SLTU = 4'd6, K_SRA = 4'd9;
  localparam logic [2:0] IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2, IM_U = 3'd3, IM_J = 3'd4;

  logic clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7_5, zero, mem_ready;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, halted, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic [20:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [20:0] vec;
    string       tag;
  } exp_t;
  exp_t sb[$];

  cpu_multicycle_control #(.RESET_PC_WAIT(RST_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .imm_src(imm_src), .halted(halted), .illegal(illegal)
  );

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_control, result_src, imm_src, halted, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] ov(input logic req, wr, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, input logic [3:0] alu,
                                     input logic [1:0] rs, input logic [2:0] imm,
                                     input logic h, il);
    return {req, wr, adr, irw, pcw, rw, a, b, alu, rs, imm, h, il};
  endfunction

  function automatic logic [20:0] v_idle();
    return ov(0,0,0,0,0,0, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 0,0);
  endfunction
  function automatic logic [20:0] v_fetch(input logic rdy);
    return ov(1,0,0,rdy,rdy,0, A_PC, B_4, K_ADD, RS_ALU, IM_I, 0,0);
  endfunction
  function automatic logic [20:0] v_decode(input logic [2:0] imm);
    return ov(0,0,0,0,0,0, A_OLD, B_IMM, K_ADD, RS_OUT, imm, 0,0);
  endfunction
  function automatic logic [20:0] v_exec(input logic [1:0] b, input logic [3:0] alu);
    return ov(0,0,0,0,0,0, A_RS1, b, alu, RS_OUT, IM_I, 0,0);
  endfunction
  function automatic logic [20:0] v_aluwb();
    return ov(0,0,0,0,0,1, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 0,0);
  endfunction
  function automatic logic [20:0] v_branch(input logic [3:0] alu, input logic take);
    return ov(0,0,0,0,take,0, A_RS1, B_RS2, alu, RS_OUT, IM_I, 0,0);
  endfunction

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.vec) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
    end
  endtask

  task automatic step(input logic [20:0] v, input string tag);
    sb.push_back('{v, tag});
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7_5 = f7;
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    sb.push_back('{v_idle(), tag});
    #1;
    check_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (RST_WAIT) step(v_idle(), {tag, "_wait"});
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    set_instr(7'b0000000, 3'b000, 1'b0);
    #2;
    sb.push_back('{v_idle(), "reset_state"});
    check_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (RST_WAIT) step(v_idle(), "reset_wait");

    // addi x1,x0,5 with memory always ready
    set_instr(7'b0010011, 3'b000, 1'b0);
    mem_ready = 1'b1;
    step(v_fetch(1), "addi_fetch");
    step(v_decode(IM_I), "addi_decode");
    step(v_exec(B_IMM, K_ADD), "addi_exec");
    step(v_aluwb(), "addi_wb");

    // lw with three wait cycles on both memory accesses
    set_instr(7'b0000011, 3'b010, 1'b0);
    mem_ready = 1'b0;
    repeat (3) step(v_fetch(0), "lw_fetch_wait");
    mem_ready = 1'b1;
    step(v_fetch(1), "lw_fetch_ready");
    step(v_decode(IM_I), "lw_decode");
    step(v_exec(B_IMM, K_ADD), "lw_memadr");
    mem_ready = 1'b0;
    repeat (3) step(ov(1,0,1,0,0,0, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 0,0), "lw_memrd_wait");
    mem_ready = 1'b1;
    step(ov(1,0,1,0,0,0, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 0,0), "lw_memrd_ready");
    step(ov(0,0,0,0,0,1, A_PC, B_RS2, K_ADD, RS_MEM, IM_I, 0,0), "lw_memwb");

    // branches
    set_instr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    step(v_fetch(1), "beq_fetch");
    step(v_decode(IM_B), "beq_decode");
    step(v_branch(K_SUB, 1), "beq_taken");
    set_instr(7'b1100011, 3'b101, 1'b0);
    zero = 1'b0;
    step(v_fetch(1), "bge_fetch");
    step(v_decode(IM_B), "bge_decode");
    step(v_branch(K_SLT, 0), "bge_not_taken");
    set_instr(7'b1100011, 3'b110, 1'b0);
    step(v_fetch(1), "bltu_fetch");
    step(v_decode(IM_B), "bltu_decode");
    step(v_branch(K_SLTU, 1), "bltu_taken");
    set_instr(7'b1100011, 3'b001, 1'b0);
    step(v_fetch(1), "bne_fetch");
    step(v_decode(IM_B), "bne_decode");
    step(v_branch(K_SUB, 1), "bne_taken");

    // funct decode
    set_instr(7'b0110011, 3'b000, 1'b1);
    step(v_fetch(1), "sub_fetch");
    step(v_decode(IM_I), "sub_decode");
    step(v_exec(B_RS2, K_SUB), "sub_exec");
    step(v_aluwb(), "sub_wb");
    set_instr(7'b0110011, 3'b111, 1'b0);
    step(v_fetch(1), "and_fetch");
    step(v_decode(IM_I), "and_decode");
    step(v_exec(B_RS2, K_AND), "and_exec");
    step(v_aluwb(), "and_wb");
    set_instr(7'b0010011, 3'b000, 1'b1);
    step(v_fetch(1), "addi_f7_fetch");
    step(v_decode(IM_I), "addi_f7_decode");
    step(v_exec(B_IMM, K_ADD), "addi_f7_exec");
    step(v_aluwb(), "addi_f7_wb");
    set_instr(7'b0010011, 3'b101, 1'b1);
    step(v_fetch(1), "srai_fetch");
    step(v_decode(IM_I), "srai_decode");
    step(v_exec(B_IMM, K_SRA), "srai_exec");
    step(v_aluwb(), "srai_wb");

    // jumps, upper immediates, fence
    set_instr(7'b1101111, 3'b000, 1'b0);
    step(v_fetch(1), "jal_fetch");
    step(v_decode(IM_J), "jal_decode");
    step(ov(0,0,0,0,1,0, A_OLD, B_4, K_ADD, RS_OUT, IM_I, 0,0), "jal_jump");
    step(v_aluwb(), "jal_wb");
    set_instr(7'b1100111, 3'b000, 1'b0);
    step(v_fetch(1), "jalr_fetch");
    step(v_decode(IM_I), "jalr_decode");
    step(v_exec(B_IMM, K_ADD), "jalr_adr");
    step(ov(0,0,0,0,1,0, A_OLD, B_4, K_ADD, RS_OUT, IM_I, 0,0), "jalr_jump");
    step(v_aluwb(), "jalr_wb");
    set_instr(7'b0110111, 3'b000, 1'b0);
    step(v_fetch(1), "lui_fetch");
    step(v_decode(IM_I), "lui_decode");
    step(ov(0,0,0,0,0,0, A_ZERO, B_IMM, K_ADD, RS_OUT, IM_U, 0,0), "lui_exec");
    step(v_aluwb(), "lui_wb");
    set_instr(7'b0010111, 3'b000, 1'b0);
    step(v_fetch(1), "auipc_fetch");
    step(v_decode(IM_I), "auipc_decode");
    step(ov(0,0,0,0,0,0, A_OLD, B_IMM, K_ADD, RS_OUT, IM_U, 0,0), "auipc_exec");
    step(v_aluwb(), "auipc_wb");
    set_instr(7'b0001111, 3'b000, 1'b0);
    step(v_fetch(1), "fence_fetch");
    step(v_decode(IM_I), "fence_decode");

    // illegal opcode traps and stays trapped
    set_instr(7'b0000000, 3'b000, 1'b0);
    step(v_fetch(1), "trap_fetch");
    step(v_decode(IM_I), "trap_decode");
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      step(ov(0,0,0,0,0,0, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 0,1), "trap_sticky");
    end
    pulse_reset("trap_clear");

    // ecall halts
    mem_ready = 1'b1;
    set_instr(7'b1110011, 3'b000, 1'b0);
    step(v_fetch(1), "ecall_fetch");
    step(v_decode(IM_I), "ecall_decode");
    repeat (3) step(ov(0,0,0,0,0,0, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 1,0), "halt_sticky");
    pulse_reset("halt_clear");

    // store interrupted by reset while the write is pending
    set_instr(7'b0100011, 3'b010, 1'b0);
    step(v_fetch(1), "sw_fetch");
    step(v_decode(IM_I), "sw_decode");
    step(ov(0,0,0,0,0,0, A_RS1, B_IMM, K_ADD, RS_OUT, IM_S, 0,0), "sw_memadr");
    mem_ready = 1'b0;
    sb.push_back('{ov(1,1,1,0,0,0, A_PC, B_RS2, K_ADD, RS_OUT, IM_I, 0,0), "sw_memwr_pending"});
    @(negedge clk);
    check_front();
    #2;
    pulse_reset("sw_reset_mid");
    mem_ready = 1'b1;
    set_instr(7'b0010011, 3'b000, 1'b0);
    step(v_fetch(1), "resume_fetch");
    step(v_decode(IM_I), "resume_decode");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
